ast_width_reducer: RTL
======================

Name: ast_width_reducer

Overview:
- Avalon-ST width down-converter that sits directly downstream of the 64->128 width up-converter.
- Accepts DATA_IN_W-bit beats with sop/eop/empty/channel and re-emits each beat as DATA_IN_W/DATA_OUT_W narrow words, first word taken from the least significant bits.
- The eop beat is trimmed so only words carrying valid bytes are sent, with a recomputed empty.
- Used to restore the 128-bit stream to 64-bit beats, and as a loop-back partner so packets can be compared end to end.

Parameters:
- DATA_IN_W, 128, input data width in bits; multiple of 8 and of DATA_OUT_W.
- DATA_OUT_W, 64, output data width in bits; multiple of 8; DATA_IN_W/DATA_OUT_W is a power of 2, at least 2.
- CHANNEL_W, 10, channel field width.
- EMPTY_IN_W, $clog2(DATA_IN_W/8), or 1 if that is 0; input empty width.
- EMPTY_OUT_W, $clog2(DATA_OUT_W/8), or 1 if that is 0; output empty width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ast_data_i  in  DATA_IN_W  input beat data.
- ast_startofpacket_i  in  1  first beat of packet.
- ast_endofpacket_i  in  1  last beat of packet.
- ast_valid_i  in  1  input beat valid.
- ast_empty_i  in  EMPTY_IN_W  unused bytes at the top of the eop beat; ignored when eop=0.
- ast_channel_i  in  CHANNEL_W  channel; constant within a packet.
- ast_ready_o  out  1  input beat accepted when valid and ready are both 1.
- ast_data_o  out  DATA_OUT_W  output word.
- ast_startofpacket_o  out  1  first word of packet.
- ast_endofpacket_o  out  1  last word of packet.
- ast_valid_o  out  1  output word valid.
- ast_empty_o  out  EMPTY_OUT_W  unused bytes at the top of the eop word; 0 otherwise.
- ast_channel_o  out  CHANNEL_W  channel of the current word.
- ast_ready_i  in  1  downstream ready.

Behaviour:
- Ratio and sizes: R = DATA_IN_W/DATA_OUT_W; IB = DATA_IN_W/8; OB = DATA_OUT_W/8.
- Reset (async, rst_i=1): state IDLE, all outputs 0 except ast_ready_o=1, word index 0, holding register 0.
- Registers: one holding register for data, sop, eop, channel and the precomputed word count N; 2-bit-or-wider word index idx (0..R-1).
- Word count per accepted beat:
  - eop=0: N = R.
  - eop=1: valid bytes V = IB - empty_in, N = ceil(V/OB), last-word empty = N*OB - V.
  - empty_in >= IB is illegal and is treated as V = OB (N=1, empty 0).
- IDLE:
  - ast_ready_o=1 and ast_valid_o=0.
  - On an input handshake: load the holding register, idx=0, go to SEND.
  - Output word 0 is presented from the next cycle, so latency is 1 cycle.
- SEND:
  - ast_data_o = hold[idx*DATA_OUT_W +: DATA_OUT_W]; ast_valid_o=1.
  - sop_o = hold_sop && idx==0.
  - eop_o = hold_eop && idx==N-1; empty_o = last-word empty on that word, else 0.
  - channel_o = hold channel.
  - Outputs stay stable while ast_ready_i=0.
  - On an output handshake with idx<N-1: idx increments.
  - On an output handshake with idx==N-1 (last word): if an input handshake occurs in the same cycle, reload the holding register, set idx=0, stay in SEND; otherwise go to IDLE.
- ast_ready_o in SEND = (idx==N-1) && ast_ready_i. This is the only combinational input-to-output path and gives back-to-back beats with no bubble.
- Throughput: one output word per cycle while ast_ready_i=1.
- Non-eop beats always emit all R words.
- A sop beat arriving without a preceding eop is forwarded as-is. The block performs no packet repair.
- Channel is captured per beat and never re-ordered.
- Reset asserted mid-packet: the partially sent beat is discarded, outputs are 0 on the next edge, and the block restarts in IDLE.

Optional Feature:
- Macro: AST_REDUCER_DATA_MASK_EN.
- When defined: bytes above the valid bytes of the eop word (the top ast_empty_o bytes) are driven to 0 on ast_data_o.
- When undefined: the holding-register bytes pass through unchanged.
- Handshake and timing are identical in both builds.

Test Plan:
- Single beat, sop=eop=1, empty_in=0, data 128'h1111..._2222...:
  - Output is 2 words: 64'h2222... (sop, empty 0), then 64'h1111... (eop, empty 0).
- Single beat, sop=eop=1, empty_in=9 (V=7):
  - Output is 1 word with sop=eop=1, empty_o=1, data = low 64 bits.
  - With AST_REDUCER_DATA_MASK_EN, byte 7 of that word is 0.
- Three-beat packet, channel 10'h2A5, empty_in=4 on eop, ast_ready_i=1 throughout, valid held high:
  - Output is 6 contiguous words, ast_valid_o high 6 consecutive cycles; sop on word 0; eop with empty_o=4 on word 5; channel 10'h2A5 on all words.
- Same packet with ast_ready_i toggling at random (seeded, delays 0..10):
  - Output word sequence is identical to the previous case.
  - Outputs stay stable during stalls; no beat is lost or duplicated.
- Back-to-back packets (1-beat eop then 2-beat), ast_ready_i=1:
  - No idle cycle between the last word of packet 1 and the first word of packet 2.
  - ast_ready_o pulses only on last-word handshakes.
- rst_i asserted while idx=1 of a 2-beat packet:
  - All outputs 0 asynchronously; ast_ready_o=1 after reset.
  - A fresh 1-beat packet then passes cleanly.

Source files
------------

// File: rtl/ast_width_reducer.sv
// Avalon-ST width down-converter: each wide beat is re-emitted as narrow words, LSB word first,
// with the eop beat trimmed to its valid words. Optional macro AST_REDUCER_DATA_MASK_EN zeroes empty bytes.
module ast_width_reducer #(
  parameter int DATA_IN_W   = 128,
  parameter int DATA_OUT_W  = 64,
  parameter int CHANNEL_W   = 10,
  parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W/8)  == 0) ? 1 : $clog2(DATA_IN_W/8),
  parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W/8) == 0) ? 1 : $clog2(DATA_OUT_W/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int R     = DATA_IN_W / DATA_OUT_W;
  localparam int IB    = DATA_IN_W / 8;
  localparam int OB    = DATA_OUT_W / 8;
  localparam int IDX_W = ($clog2(R) < 2) ? 2 : $clog2(R);
  localparam int N_W   = IDX_W + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state;
  logic [DATA_IN_W-1:0]   hold_data;
  logic                   hold_sop;
  logic                   hold_eop;
  logic [CHANNEL_W-1:0]   hold_ch;
  logic [N_W-1:0]         hold_n;
  logic [EMPTY_OUT_W-1:0] hold_le;
  logic [IDX_W-1:0]       idx;

  int                     v_bytes;
  int                     n_words;
  logic [N_W-1:0]         beat_n;
  logic [EMPTY_OUT_W-1:0] beat_le;
  logic                   idx_last;
  logic                   in_hs;
  logic                   send;
  logic                   eop_word;
  logic [DATA_OUT_W-1:0]  word;

  // An out-of-range empty is clamped to one full output word.
  always_comb begin
    v_bytes = IB;
    if (ast_endofpacket_i)
      v_bytes = (int'(ast_empty_i) >= IB) ? OB : IB - int'(ast_empty_i);
    n_words = (v_bytes + OB - 1) / OB;
    beat_n  = N_W'(n_words);
    beat_le = EMPTY_OUT_W'(n_words * OB - v_bytes);
  end

  assign send        = (state == SEND);
  assign idx_last    = ({1'b0, idx} == (hold_n - N_W'(1)));
  assign ast_ready_o = (state == IDLE) || (idx_last && ast_ready_i);
  assign in_hs       = ast_valid_i && ast_ready_o;
  assign eop_word    = send && hold_eop && idx_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      hold_data <= '0;
      hold_sop  <= 1'b0;
      hold_eop  <= 1'b0;
      hold_ch   <= '0;
      hold_n    <= '0;
      hold_le   <= '0;
      idx       <= '0;
    end else begin
      unique case (state)
        IDLE: if (ast_valid_i) state <= SEND;
        SEND: if (ast_ready_i && idx_last && !ast_valid_i) state <= IDLE;
      endcase
      if (in_hs) begin
        hold_data <= ast_data_i;
        hold_sop  <= ast_startofpacket_i;
        hold_eop  <= ast_endofpacket_i;
        hold_ch   <= ast_channel_i;
        hold_n    <= beat_n;
        hold_le   <= ast_endofpacket_i ? beat_le : '0;
        idx       <= '0;
      end else if (send && ast_ready_i && !idx_last) begin
        idx <= idx + 1'b1;
      end
    end
  end

  always_comb begin
    word = hold_data[idx*DATA_OUT_W +: DATA_OUT_W];
`ifdef AST_REDUCER_DATA_MASK_EN
    if (eop_word) begin
      for (int b = 0; b < OB; b++)
        if (b >= OB - int'(hold_le)) word[b*8 +: 8] = 8'h00;
    end
`endif
  end

  assign ast_valid_o         = send;
  assign ast_data_o          = send ? word : '0;
  assign ast_startofpacket_o = send && hold_sop && (idx == '0);
  assign ast_endofpacket_o   = eop_word;
  assign ast_empty_o         = eop_word ? hold_le : '0;
  assign ast_channel_o       = send ? hold_ch : '0;

endmodule
